// File: rtl/ball_move_ctrl.sv
// ball_move_ctrl: per-frame ball stepper with wall checks and goal latch; `define BALL_DIAG_EN to move both axes at once
module ball_move_ctrl #(
  parameter int X_START  = 30,
  parameter int Y_START  = 30,
  parameter int BALL_W   = 10,
  parameter int STEP_MAX = 4,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 630,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 470,
  parameter int GOAL_X0  = 449,
  parameter int GOAL_X1  = 459,
  parameter int GOAL_Y0  = 20,
  parameter int GOAL_Y1  = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        dir_up,
  input  logic        dir_down,
  input  logic        dir_left,
  input  logic        dir_right,
  input  logic        stop_up,
  input  logic        stop_down,
  input  logic        stop_left,
  input  logic        stop_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [4:0]  ball_width,
  output logic        busy,
  output logic        win
);
  localparam logic [10:0] XS  = 11'(X_START);
  localparam logic [10:0] YS  = 11'(Y_START);
  localparam logic [10:0] XLO = 11'(X_MIN);
  localparam logic [10:0] XHI = 11'(X_MAX);
  localparam logic [10:0] YLO = 11'(Y_MIN);
  localparam logic [10:0] YHI = 11'(Y_MAX);
  localparam logic [10:0] GX0 = 11'(GOAL_X0);
  localparam logic [10:0] GX1 = 11'(GOAL_X1 - BALL_W + 1);
  localparam logic [10:0] GY0 = 11'(GOAL_Y0);
  localparam logic [10:0] GY1 = 11'(GOAL_Y1 - BALL_W + 1);
  localparam logic [3:0]  SMX = 4'(STEP_MAX);
  typedef enum logic [1:0] {IDLE, SETTLE, STEP, WIN} state_t;
  state_t state;
  logic [3:0] dir_q, step_cnt;
  logic mv_r, mv_l, mv_d, mv_u, h_mv, v_mv, moved, goal;
  logic [10:0] x_nxt, y_nxt;
  assign ball_width = 5'(BALL_W);
  // dir_q = {up, down, left, right}; opposing requests cancel per axis
  always_comb begin
    mv_r  = dir_q[0] && !dir_q[1] && !stop_right && x_ball < XHI;
    mv_l  = dir_q[1] && !dir_q[0] && !stop_left  && x_ball > XLO;
    mv_d  = dir_q[2] && !dir_q[3] && !stop_down  && y_ball < YHI;
    mv_u  = dir_q[3] && !dir_q[2] && !stop_up    && y_ball > YLO;
    h_mv  = mv_r || mv_l;
`ifdef BALL_DIAG_EN
    v_mv  = mv_d || mv_u;
`else
    v_mv  = (mv_d || mv_u) && !h_mv;
`endif
    moved = h_mv || v_mv;
    x_nxt = mv_r ? x_ball + 11'd1 : mv_l ? x_ball - 11'd1 : x_ball;
    y_nxt = !v_mv ? y_ball : mv_d ? y_ball + 11'd1 : y_ball - 11'd1;
    goal  = x_nxt >= GX0 && x_nxt <= GX1 && y_nxt >= GY0 && y_nxt <= GY1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_ball   <= XS;
      y_ball   <= YS;
      busy     <= 1'b0;
      win      <= 1'b0;
      step_cnt <= 4'd0;
      dir_q    <= 4'd0;
    end else begin
      case (state)
        IDLE: if (frame_tick && (dir_up || dir_down || dir_left || dir_right)) begin
          dir_q    <= {dir_up, dir_down, dir_left, dir_right};
          step_cnt <= SMX;
          busy     <= 1'b1;
          state    <= SETTLE;
        end
        SETTLE: state <= STEP;
        STEP: begin
          x_ball   <= x_nxt;
          y_ball   <= y_nxt;
          step_cnt <= moved ? step_cnt - 4'd1 : step_cnt;
          if (!moved || step_cnt == 4'd1 || goal) busy <= 1'b0;
          win      <= win || (moved && goal);
          state    <= !moved ? IDLE : goal ? WIN : step_cnt == 4'd1 ? IDLE : SETTLE;
        end
        default: state <= WIN;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_move_ctrl.sv
// tb_ball_move_ctrl: directed scoreboard bench for the ball stepper and goal latch
module tb_ball_move_ctrl;
  logic clk = 0, rst = 0, frame_tick = 0;
  logic dir_up = 0, dir_down = 0, dir_left = 0, dir_right = 0, stop_en = 0;
  logic g_tick = 0, g_right = 0;
  logic [10:0] x_ball, y_ball, g_x, g_y;
  logic [4:0] ball_width, g_w;
  logic busy, win, g_busy, g_win, stop_right;
  int checks = 0, errors = 0, cyc;
  int exp_q[$];
  always #5 clk = ~clk;
  assign stop_right = stop_en && x_ball == 11'd32;
  ball_move_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .stop_up(1'b0), .stop_down(1'b0), .stop_left(1'b0), .stop_right(stop_right),
    .x_ball(x_ball), .y_ball(y_ball), .ball_width(ball_width), .busy(busy), .win(win)
  );
  ball_move_ctrl #(.X_START(448), .Y_START(25)) gdut (
    .clk(clk), .rst(rst), .frame_tick(g_tick),
    .dir_up(1'b0), .dir_down(1'b0), .dir_left(1'b0), .dir_right(g_right),
    .stop_up(1'b0), .stop_down(1'b0), .stop_left(1'b0), .stop_right(1'b0),
    .x_ball(g_x), .y_ball(g_y), .ball_width(g_w), .busy(g_busy), .win(g_win)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic fire(input logic u, input logic d, input logic l, input logic r);
    {dir_up, dir_down, dir_left, dir_right} = {u, d, l, r};
    frame_tick = 1;
    step();
    frame_tick = 0;
    {dir_up, dir_down, dir_left, dir_right} = 4'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      step();
    end
  endtask
  initial begin
    do_reset();
    exp_q.push_back(30); exp_q.push_back(30); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(10);
    chk("rst_x", x_ball); chk("rst_y", y_ball); chk("rst_busy", busy);
    chk("rst_win", win); chk("width", ball_width);
    // plain right move: first change at k+3, busy 2*STEP_MAX cycles
    exp_q.push_back(1); exp_q.push_back(30); exp_q.push_back(30); exp_q.push_back(31);
    exp_q.push_back(8); exp_q.push_back(34); exp_q.push_back(30);
    fire(0, 0, 0, 1);
    chk("r_busy_k1", busy); chk("r_x_k1", x_ball);
    step(); chk("r_x_k2", x_ball);
    step(); chk("r_x_k3", x_ball);
    wait_idle(cyc);
    chk("r_busy_cycles", cyc + 2); chk("r_x_end", x_ball); chk("r_y_end", y_ball);
    // wall at x=32 aborts the frame early
    do_reset();
    stop_en = 1;
    exp_q.push_back(6); exp_q.push_back(32); exp_q.push_back(30);
    fire(0, 0, 0, 1);
    wait_idle(cyc);
    chk("stop_busy_cycles", cyc); chk("stop_x", x_ball); chk("stop_y", y_ball);
    // left+right cancel: abort at first STEP
    exp_q.push_back(2); exp_q.push_back(32); exp_q.push_back(30);
    fire(0, 0, 1, 1);
    wait_idle(cyc);
    chk("cancel_busy_cycles", cyc); chk("cancel_x", x_ball); chk("cancel_y", y_ball);
    stop_en = 0;
    // right+down combination
    do_reset();
    exp_q.push_back(34);
`ifdef BALL_DIAG_EN
    exp_q.push_back(34);
`else
    exp_q.push_back(30);
`endif
    fire(0, 1, 0, 1);
    wait_idle(cyc);
    chk("rd_x", x_ball); chk("rd_y", y_ball);
    // reset during the third pixel
    do_reset();
    exp_q.push_back(32); exp_q.push_back(30); exp_q.push_back(30);
    exp_q.push_back(0); exp_q.push_back(0);
    fire(0, 0, 0, 1);
    step(); step(); step(); step();
    chk("mid_x_before", x_ball);
    rst = 1;
    step();
    rst = 0;
    chk("mid_x", x_ball); chk("mid_y", y_ball); chk("mid_busy", busy); chk("mid_win", win);
    // goal entry on the second instance
    exp_q.push_back(0); exp_q.push_back(449); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(449); exp_q.push_back(25); exp_q.push_back(1); exp_q.push_back(0);
    g_right = 1; g_tick = 1;
    step();
    g_tick = 0; g_right = 0;
    step();
    chk("g_win_k2", g_win);
    step();
    chk("g_x_k3", g_x); chk("g_win_k3", g_win); chk("g_busy_k3", g_busy);
    g_right = 1; g_tick = 1;
    step();
    g_tick = 0; g_right = 0;
    for (int i = 0; i < 12; i++) step();
    chk("g_x_hold", g_x); chk("g_y_hold", g_y); chk("g_win_hold", g_win); chk("g_busy_hold", g_busy);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
